// File: rtl/gry_cnt_rcvr.sv
// gry_cnt_rcvr: synchronizes a foreign-domain gray count, converts it to binary and
// checks every observed change for a legal single +1 gray step.
module gry_cnt_rcvr #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EVT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     rst_val,
  input  logic [WIDTH-1:0]     gry_cnt_in,
  input  logic                 clr,
  output logic [WIDTH-1:0]     gry_cnt_sync,
  output logic [WIDTH-1:0]     bin_cnt,
  output logic                 inc_pls,
  output logic                 err_pls,
  output logic                 err_sticky,
  output logic                 locked,
  output logic [EVT_WIDTH-1:0] evt_cnt
);
  localparam int FW = $clog2(SYNC_STAGES);
  localparam logic [FW-1:0] FILL_LAST = FW'(SYNC_STAGES - 1);
  typedef enum logic [1:0] {FILL, TRACK, ERR} state_e;
  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q, bin_q, bin_d, diff;
  logic [EVT_WIDTH-1:0] evt_q, evt_d;
  logic [FW-1:0] fill_q, fill_d;
  logic inc_q, inc_d, err_q, err_d, sticky_q, sticky_d, chg, legal, bad;
  state_e state_q, state_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= rst_val;
    end else begin
      sync_q[0] <= gry_cnt_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  assign gry_cnt_sync = sync_q[SYNC_STAGES-1];
  assign diff  = gry_cnt_sync ^ prev_q;
  assign chg   = |diff;
  assign legal = $onehot(diff) && (g2b(gry_cnt_sync) == g2b(prev_q) + WIDTH'(1));
  assign bad   = chg && !legal;
  assign bin_d = chg ? g2b(gry_cnt_sync) : bin_q;
  // An error always beats clr; clr with a legal step in TRACK restarts the tally at 1.
  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    evt_d    = evt_q;
    sticky_d = sticky_q;
    inc_d    = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      FILL: begin
        fill_d  = fill_q + 1'b1;
        state_d = (fill_q == FILL_LAST) ? TRACK : FILL;
      end
      TRACK: begin
        inc_d    = legal;
        err_d    = bad;
        sticky_d = bad | (sticky_q & ~clr);
        state_d  = bad ? ERR : TRACK;
        evt_d    = clr ? EVT_WIDTH'(legal) : (legal && evt_q != '1) ? evt_q + 1'b1 : evt_q;
      end
      ERR: begin
        err_d    = bad;
        sticky_d = bad | (sticky_q & ~clr);
        state_d  = (clr && !bad) ? TRACK : ERR;
        evt_d    = clr ? '0 : evt_q;
      end
      default: state_d = FILL;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q   <= rst_val;
      bin_q    <= g2b(rst_val);
      inc_q    <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      evt_q    <= '0;
      fill_q   <= '0;
      state_q  <= FILL;
    end else begin
      prev_q   <= gry_cnt_sync;
      bin_q    <= bin_d;
      inc_q    <= inc_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      evt_q    <= evt_d;
      fill_q   <= fill_d;
      state_q  <= state_d;
    end
  end
  assign bin_cnt    = bin_q;
  assign inc_pls    = inc_q;
  assign err_pls    = err_q;
  assign err_sticky = sticky_q;
  assign evt_cnt    = evt_q;
  assign locked     = (state_q == TRACK);
endmodule

// File: tb/tb_gry_cnt_rcvr.sv
// tb_gry_cnt_rcvr: directed and random gray streams checked against a table-driven
// reference model; a second instance with a 2-bit tally exercises saturation.
module tb_gry_cnt_rcvr;
  localparam int S = 2;
  logic clk = 1'b0, rst = 1'b1, clr = 1'b0;
  logic [7:0] rv = '0, gin = '0;
  logic [7:0] a_sync, a_bin, a_evt, b_sync, b_bin;
  logic a_inc, a_err, a_stk, a_lck, b_inc, b_err, b_stk, b_lck;
  logic [1:0] b_evt;
  gry_cnt_rcvr #(.WIDTH(8), .SYNC_STAGES(S), .EVT_WIDTH(8)) u_a (
    .clk(clk), .rst(rst), .rst_val(rv), .gry_cnt_in(gin), .clr(clr),
    .gry_cnt_sync(a_sync), .bin_cnt(a_bin), .inc_pls(a_inc), .err_pls(a_err),
    .err_sticky(a_stk), .locked(a_lck), .evt_cnt(a_evt));
  gry_cnt_rcvr #(.WIDTH(8), .SYNC_STAGES(S), .EVT_WIDTH(2)) u_b (
    .clk(clk), .rst(rst), .rst_val(rv), .gry_cnt_in(gin), .clr(clr),
    .gry_cnt_sync(b_sync), .bin_cnt(b_bin), .inc_pls(b_inc), .err_pls(b_err),
    .err_sticky(b_stk), .locked(b_lck), .evt_cnt(b_evt));
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  int tab [256];
  int m_sh [S];
  int m_prev, m_bin, m_st, m_fill, m_e8, m_e2;
  bit m_inc, m_err, m_stk;
  function automatic int gray(int b);
    return (b ^ (b >> 1)) & 255;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // m_st: 0 = filling the synchronizer, 1 = tracking, 2 = error hold
  task automatic model();
    int cur, p;
    bit step, bad;
    if (rst) begin
      for (int i = 0; i < S; i++) m_sh[i] = rv;
      m_prev = rv; m_bin = tab[rv]; m_inc = 0; m_err = 0; m_stk = 0;
      m_e8 = 0; m_e2 = 0; m_st = 0; m_fill = 0;
    end else begin
      cur = m_sh[S-1];
      for (int i = S - 1; i > 0; i--) m_sh[i] = m_sh[i-1];
      m_sh[0] = gin;
      p = m_prev;
      m_prev = cur;
      step = tab[cur] == (tab[p] + 1) % 256;
      bad = (cur != p) && !step;
      if (cur != p) m_bin = tab[cur];
      m_inc = 0; m_err = 0;
      if (m_st == 0) begin
        if (m_fill == S - 1) m_st = 1; else m_fill++;
      end else if (bad) begin
        m_err = 1; m_stk = 1; m_st = 2;
        if (clr) begin m_e8 = 0; m_e2 = 0; end
      end else if (m_st == 1) begin
        if (clr) begin m_stk = 0; m_e8 = step; m_e2 = step; end
        else if (step) begin
          m_e8 = (m_e8 < 255) ? m_e8 + 1 : 255;
          m_e2 = (m_e2 < 3) ? m_e2 + 1 : 3;
        end
        m_inc = step;
      end else if (clr) begin
        m_st = 1; m_stk = 0; m_e8 = 0; m_e2 = 0;
      end
    end
  endtask
  task automatic tick();
    model();
    @(posedge clk);
    #1;
    chk("sync", a_sync, m_sh[S-1]);
    chk("bin", a_bin, m_bin);
    chk("inc", a_inc, m_inc);
    chk("err", a_err, m_err);
    chk("sticky", a_stk, m_stk);
    chk("locked", a_lck, m_st == 1);
    chk("evt8", a_evt, m_e8);
    chk("evt2", b_evt, m_e2);
    chk("inc_b", b_inc, m_inc);
    chk("locked_b", b_lck, m_st == 1);
  endtask
  task automatic hold(int n);
    repeat (n) tick();
  endtask
  task automatic step_to(int v, int n);
    gin = v[7:0];
    hold(n);
  endtask
  task automatic do_reset(int v);
    rst = 1'b1; rv = v[7:0]; gin = v[7:0];
    hold(2);
    rst = 1'b0;
    hold(S);
  endtask
  initial begin
    int r, n;
    for (int b = 0; b < 256; b++) tab[gray(b)] = b;
    hold(2);
    rst = 1'b0;
    tick();
    chk("lock_early", a_lck, 0);
    tick();
    chk("lock_rise", a_lck, 1);
    step_to(8'h01, 4); step_to(8'h03, 4); step_to(8'h02, 4);
    chk("seq_bin", a_bin, 3);
    chk("seq_evt", a_evt, 3);
    do_reset(8'h80);
    step_to(8'h00, 4);
    chk("wrap_bin", a_bin, 0);
    chk("wrap_evt", a_evt, 1);
    chk("wrap_sticky", a_stk, 0);
    do_reset(8'h00);
    step_to(8'h01, 4); step_to(8'h03, 4); step_to(8'h06, 4);
    chk("jump_bin", a_bin, 4);
    chk("jump_sticky", a_stk, 1);
    chk("jump_locked", a_lck, 0);
    step_to(8'h07, 4);
    chk("err_frozen", a_evt, 2);
    clr = 1'b1; tick(); clr = 1'b0; tick();
    chk("clr_locked", a_lck, 1);
    chk("clr_evt", a_evt, 0);
    chk("clr_sticky", a_stk, 0);
    do_reset(8'h02);
    step_to(8'h03, 4);
    chk("dec_bin", a_bin, 2);
    chk("dec_sticky", a_stk, 1);
    do_reset(8'h00);
    for (int b = 1; b <= 5; b++) step_to(gray(b), 4);
    chk("sat_evt", b_evt, 3);
    gin = 8'(gray(6)); tick(); tick();
    clr = 1'b1; tick(); clr = 1'b0;
    chk("sat_clr_evt2", b_evt, 1);
    chk("sat_clr_evt8", a_evt, 1);
    do_reset(8'hC0);
    chk("rv_bin", a_bin, 128);
    chk("rv_sync", a_sync, 8'hC0);
    for (int b = 129; b <= 131; b++) step_to(gray(b), 3);
    rst = 1'b1; rv = 8'h00; tick(); rst = 1'b0;
    chk("mid_rst_lock", a_lck, 0);
    hold(S);
    for (int k = 0; k < 800; k++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset($urandom_range(0, 255));
      end else begin
        gin = (r < 10) ? 8'($urandom_range(0, 255)) : 8'(gray((tab[gin] + 1) % 256));
        clr = ($urandom_range(0, 19) == 0);
        n = $urandom_range(1, 4);
        tick();
        clr = 1'b0;
        hold(n - 1);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gry_cnt_rcvr.md
# gry_cnt_rcvr

Receive-side companion to the gray code counter. It samples a gray-coded count driven from another clock domain through a parameterized synchronizer chain and converts it to binary. It checks every observed change for a legal single-step gray increment and reports increments, illegal transitions and a saturating event tally. It sits at the far end of cross-domain pointer/count paths, such as async FIFO read/write pointer consumers and frame or sample counters.

## Interface
- WIDTH, 8, width of gray count and binary count.
- SYNC_STAGES, 2, synchronizer flop depth; legal range 2..4.
- EVT_WIDTH, 8, width of saturating event counter.

- clk  input  1  single clock for the whole block.
- rst  input  1  synchronous, active-high reset.
- rst_val  input  WIDTH  gray reset value; must equal the transmitting counter's reset value; static.
- gry_cnt_in  input  WIDTH  gray count from the foreign domain; asynchronous to clk.
- clr  input  1  clears evt_cnt and err_sticky and leaves ERR state.
- gry_cnt_sync  output  WIDTH  last synchronizer stage (gray).
- bin_cnt  output  WIDTH  binary value of the tracked count.
- inc_pls  output  1  one-cycle pulse per legal +1 step.
- err_pls  output  1  one-cycle pulse per illegal transition.
- err_sticky  output  1  set on any error; cleared by clr.
- locked  output  1  high while in TRACK.
- evt_cnt  output  EVT_WIDTH  saturating count of inc_pls.

## Operation
- Reset (rst=1 at a clk edge):
  - all sync stages and prev_gry load rst_val;
  - bin_cnt loads gray2bin(rst_val);
  - inc_pls=0, err_pls=0, err_sticky=0, evt_cnt=0, locked=0;
  - state=FILL, fill counter=0.
- Reset mid-operation overrides every other event in that cycle.
- gray2bin: bin[i] = XOR of gry[WIDTH-1:i].
- Compare each cycle: diff = gry_cnt_sync ^ prev_gry; prev_gry <= gry_cnt_sync every cycle.
  - diff==0: no event.
  - popcount(diff)==1 and gray2bin(sync)==gray2bin(prev)+1 mod 2^WIDTH: legal step. Includes wrap from all-ones binary to 0.
  - any other nonzero diff: illegal. This covers a decrement or a multi-bit change.
- bin_cnt <= gray2bin(gry_cnt_sync) on every change, legal or not. Resync is always allowed.
- State machine:
  - FILL: counts SYNC_STAGES cycles; inc_pls and err_pls are forced 0; bin_cnt and prev_gry still update. Goes to TRACK when the fill counter reaches SYNC_STAGES-1.
  - TRACK: locked=1. Legal step -> inc_pls=1, evt_cnt+1 saturating at all-ones. Illegal -> err_pls=1, err_sticky=1, next state ERR.
  - ERR: locked=0. inc_pls suppressed and evt_cnt frozen. Illegal steps still pulse err_pls. clr -> TRACK next cycle.
- clr:
  - in TRACK or ERR: evt_cnt<=0 and err_sticky<=0.
  - clr together with a legal step in TRACK: evt_cnt<=1.
  - clr together with an illegal step: the error wins; err_sticky=1 and state stays/enters ERR; evt_cnt<=0.
  - clr in FILL is ignored.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- gry_cnt_in change to gry_cnt_sync: SYNC_STAGES cycles.
- gry_cnt_in change to bin_cnt, inc_pls or err_pls: SYNC_STAGES+1 cycles.
- inc_pls to evt_cnt increment: evt_cnt updates in the same cycle inc_pls is high.
- After rst is released, locked rises SYNC_STAGES cycles later.
- Back-to-back legal steps every clk cycle each produce an inc_pls; no coalescing.
- The source must change no faster than once per 2 clk cycles for guaranteed single-step visibility. Faster changes produce err_pls, which is the correct response.

## Test plan
- WIDTH=8, SYNC_STAGES=2, rst_val=8'h00, release rst -> locked=0 for 2 cycles then 1; bin_cnt=0; evt_cnt=0; no pulses.
- Drive gray 0x00,0x01,0x03,0x02 one change per 4 clks -> three inc_pls each 3 clks after the change; bin_cnt=1,2,3; evt_cnt=3.
- Start from binary 255 (gray 0x80), step to gray 0x00 -> inc_pls=1, bin_cnt=0, no error (wrap).
- From gray 0x03 jump to 0x06 (two-bit change) -> err_pls=1, err_sticky=1, locked=0, bin_cnt=4. A following legal step gives no inc_pls. Then clr -> locked=1, evt_cnt=0, err_sticky=0.
- Decrement: gray 0x02 -> 0x03 -> err_pls=1, bin_cnt=2.
- EVT_WIDTH=2, five legal steps -> evt_cnt saturates at 3. clr coincident with a sixth step -> evt_cnt=1.
- rst_val=8'hC0 (binary 128) -> after reset bin_cnt=128, gry_cnt_sync=0xC0. Assert rst mid-stream -> all outputs return to reset values on the next edge.
